uart_rx: RTL

- Serial UART receiver: the inbound counterpart to the byte-output uart slave.
- Samples an asynchronous 8N1 rx line and assembles bytes.
- Buffers received bytes in a small FIFO.
- Exposes data and status to the CPU as a Wishbone slave on the system bus, alongside the existing uart block.

---
 rtl/uart_rx_pkg.sv | 11 +
 rtl/uart_rx_fifo.sv | 43 ++++
 rtl/uart_rx.sv | 131 +++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared register offsets, STATUS bit positions and receiver FSM states.
package uart_rx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
    localparam logic [3:0] RXDATA_OFS = 4'h0;
    localparam logic [3:0] STATUS_OFS = 4'h8;
    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL = 1;
    localparam int ST_OVERRUN = 2;
    localparam int ST_FRAME_ERR = 3;
    localparam int ST_COUNT_LSB = 8;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO holding received bytes.
//   clk_i/rst_i : clock, async active-low reset
//   push/din    : write request and data (dropped when full unless popping)
//   pop/dout    : read request and head entry
//   full/empty/count : occupancy status
module uart_rx_fifo import uart_rx_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_push, do_pop;
    assign full = count == NW'(DEPTH);
    assign empty = count == '0;
    // A pop frees the slot being written, so a full FIFO still accepts a push.
    assign do_push = push & (~full | pop);
    assign do_pop = pop & ~empty;
    assign dout = mem[rptr];
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + NW'(do_push) - NW'(do_pop);
        end
    always_ff @(posedge clk_i)
        if (do_push) mem[wptr] <= din;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with byte FIFO and Wishbone slave register interface.
//   clk_i/rst_i   : clock, async active-low reset
//   urx_*         : Wishbone slave (RXDATA at 0x0, STATUS at 0x8; only adr[3] decoded)
//   uart_rx_i     : asynchronous serial input, idles high
module uart_rx import uart_rx_pkg::*; #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD = 115200,
    parameter int FIFO_DEPTH = 8,
    parameter int DAT_WIDTH = 64,
    parameter int ADR_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   urx_cyc_i,
    input  logic                   urx_stb_i,
    input  logic                   urx_we_i,
    input  logic [ADR_WIDTH-1:0]   urx_adr_i,
    input  logic [DAT_WIDTH-1:0]   urx_dat_i,
    input  logic [DAT_WIDTH/8-1:0] urx_sel_i,
    output logic [DAT_WIDTH-1:0]   urx_dat_o,
    output logic                   urx_ack_o,
    output logic                   urx_err_o,
    input  logic                   uart_rx_i
);
    localparam int CPB = CLK_FREQ / BAUD;
    localparam int CW = $clog2(CPB);
    localparam int NW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CPB - 1);
    logic rx_s1, rx, push, frame_set, full, empty, overrun, frame_err;
    logic req, is_stat, pop, wr_stat, ack_q, err_q;
    rx_state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0] idx, idx_nx;
    logic [7:0] sh, sh_nx, head;
    logic [NW-1:0] count;
    logic [15:0] stat;
    logic [DAT_WIDTH-1:0] rx_word, dat_q;
    logic unused;
    assign unused = ^{urx_sel_i, urx_adr_i[ADR_WIDTH-1:4], urx_adr_i[2:0],
                      urx_dat_i[DAT_WIDTH-1:4], urx_dat_i[1:0]};
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) {rx, rx_s1} <= 2'b11;
        else {rx, rx_s1} <= {rx_s1, uart_rx_i};
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            sh <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            idx <= idx_nx;
            sh <= sh_nx;
        end
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        idx_nx = idx;
        sh_nx = sh;
        push = 1'b0;
        frame_set = 1'b0;
        case (state)
            IDLE: if (!rx) begin
                state_nx = START;
                cnt_nx = HALF;
            end
            START: if (cnt != '0) cnt_nx = cnt - 1'b1;
                else if (rx) state_nx = IDLE;
                else begin
                    state_nx = DATA;
                    idx_nx = '0;
                    cnt_nx = FULL;
                end
            DATA: if (cnt != '0) cnt_nx = cnt - 1'b1;
                else begin
                    sh_nx = {rx, sh[7:1]};
                    cnt_nx = FULL;
                    idx_nx = idx + 1'b1;
                    if (idx == 3'd7) state_nx = STOP;
                end
            STOP: if (cnt != '0) cnt_nx = cnt - 1'b1;
                else if (rx) begin
                    push = 1'b1;
                    state_nx = IDLE;
                end else begin
                    frame_set = 1'b1;
                    state_nx = BREAK;
                end
            BREAK: if (rx) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    uart_rx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .push(push), .pop(pop), .din(sh),
        .dout(head), .full(full), .empty(empty), .count(count)
    );
    // The cycle after an ack/err never starts a new request, so one transfer pops at most once.
    assign req = urx_cyc_i & urx_stb_i & ~(ack_q | err_q);
    assign is_stat = urx_adr_i[3] == STATUS_OFS[3];
    assign pop = req & ~urx_we_i & ~is_stat & ~empty;
    assign wr_stat = req & urx_we_i & is_stat;
    assign rx_word = {{(DAT_WIDTH-9){1'b0}}, ~empty, empty ? 8'h00 : head};
    always_comb begin
        stat = '0;
        stat[ST_NOT_EMPTY] = ~empty;
        stat[ST_FULL] = full;
        stat[ST_OVERRUN] = overrun;
        stat[ST_FRAME_ERR] = frame_err;
        stat[ST_COUNT_LSB +: 8] = 8'(count);
    end
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            overrun <= 1'b0;
            frame_err <= 1'b0;
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
        end else begin
            // Set dominates a same-cycle write-1-to-clear.
            overrun <= (push & full & ~pop) | (overrun & ~(wr_stat & urx_dat_i[ST_OVERRUN]));
            frame_err <= frame_set | (frame_err & ~(wr_stat & urx_dat_i[ST_FRAME_ERR]));
            ack_q <= req & ~(urx_we_i & ~is_stat);
            err_q <= req & urx_we_i & ~is_stat;
            dat_q <= (req & ~urx_we_i) ? (is_stat ? DAT_WIDTH'(stat) : rx_word) : '0;
        end
    assign urx_dat_o = dat_q;
    assign urx_ack_o = ack_q & urx_stb_i;
    assign urx_err_o = err_q & urx_stb_i;
endmodule
